// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator
// Polyphonic voice scheduler. Each accepted note event is resolved over a
// per-slot scan (same-note match, then a free slot, then the oldest gated
// slot) and committed to the per-voice note/velocity/gate registers that the
// oscillator and envelope voices consume.
module midi_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic                      ev_on,
    input  logic [6:0]                ev_note,
    input  logic [6:0]                ev_vel,
    input  logic                      panic,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [7*NUM_VOICES-1:0]   voice_note,
    output logic [7*NUM_VOICES-1:0]   voice_vel,
    output logic [NUM_VOICES-1:0]     voice_trig,
    output logic                      steal
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = '1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]        state;
    logic [IDX_W-1:0]  scan_idx;

    // Event fields captured at accept; a zero-velocity note-on is stored as an off.
    logic              lat_on;
    logic [6:0]        lat_note;
    logic [6:0]        lat_vel;

    // Candidates gathered while scanning the slots one by one.
    logic              match_found;
    logic [IDX_W-1:0]  match_idx;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              old_found;
    logic [IDX_W-1:0]  old_idx;
    logic [AGE_W-1:0]  old_age;

    // Per-slot state.
    logic [NUM_VOICES-1:0] gate_r;
    logic [6:0]            note_r [NUM_VOICES];
    logic [6:0]            vel_r  [NUM_VOICES];
    logic [AGE_W-1:0]      age_r  [NUM_VOICES];
    logic [NUM_VOICES-1:0] trig_r;
    logic                  steal_r;

    // View of the slot currently under the scan index.
    logic              cur_gate;
    logic [6:0]        cur_note;
    logic [AGE_W-1:0]  cur_age;

    // Final decision derived from the scan candidates, used in COMMIT.
    logic              sel_valid;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_steal;

    assign ev_ready = (state == ST_IDLE);

    // Pick out the slot being examined this scan cycle.
    always_comb begin
        cur_gate = gate_r[scan_idx];
        cur_note = note_r[scan_idx];
        cur_age  = age_r[scan_idx];
    end

    // Resolve the scan candidates into one target slot: note-on prefers a
    // same-note retrigger, then a free slot, then stealing the oldest gated
    // slot; note-off only ever acts on a matching gated slot.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_steal = 1'b0;
        if (lat_on) begin
            if (match_found) begin
                sel_valid = 1'b1;
                sel_idx   = match_idx;
            end else if (free_found) begin
                sel_valid = 1'b1;
                sel_idx   = free_idx;
            end else if (old_found) begin
                sel_valid = 1'b1;
                sel_idx   = old_idx;
                sel_steal = 1'b1;
            end
        end else if (match_found) begin
            sel_valid = 1'b1;
            sel_idx   = match_idx;
        end
    end

    // Control FSM: latch the event, walk the slots collecting candidates,
    // then spend one cycle committing. Panic aborts any event in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            scan_idx    <= '0;
            lat_on      <= 1'b0;
            lat_note    <= '0;
            lat_vel     <= '0;
            match_found <= 1'b0;
            match_idx   <= '0;
            free_found  <= 1'b0;
            free_idx    <= '0;
            old_found   <= 1'b0;
            old_idx     <= '0;
            old_age     <= '0;
        end else if (panic) begin
            state    <= ST_IDLE;
            scan_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ev_valid) begin
                        state       <= ST_SCAN;
                        scan_idx    <= '0;
                        lat_on      <= ev_on && (ev_vel != 7'd0);
                        lat_note    <= ev_note;
                        lat_vel     <= ev_vel;
                        match_found <= 1'b0;
                        match_idx   <= '0;
                        free_found  <= 1'b0;
                        free_idx    <= '0;
                        old_found   <= 1'b0;
                        old_idx     <= '0;
                        old_age     <= '0;
                    end
                end
                ST_SCAN: begin
                    if (cur_gate && (cur_note == lat_note) && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!cur_gate && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    if (cur_gate && (!old_found || (cur_age > old_age))) begin
                        old_found <= 1'b1;
                        old_idx   <= scan_idx;
                        old_age   <= cur_age;
                    end
                    if (scan_idx == LAST_IDX) begin
                        state <= ST_COMMIT;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Slot registers and one-cycle pulses. A note-on loads the chosen slot
    // and ages every other held slot; a note-off only drops the gate so the
    // release phase keeps its note and velocity. Panic silences everything
    // but leaves note/velocity for the envelopes to release on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_r  <= '0;
            trig_r  <= '0;
            steal_r <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= '0;
                vel_r[i]  <= '0;
                age_r[i]  <= '0;
            end
        end else if (panic) begin
            gate_r  <= '0;
            trig_r  <= '0;
            steal_r <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                age_r[i] <= '0;
            end
        end else begin
            trig_r  <= '0;
            steal_r <= 1'b0;
            if ((state == ST_COMMIT) && sel_valid) begin
                if (lat_on) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (IDX_W'(i) == sel_idx) begin
                            gate_r[i] <= 1'b1;
                            note_r[i] <= lat_note;
                            vel_r[i]  <= lat_vel;
                            age_r[i]  <= '0;
                        end else if (gate_r[i] && (age_r[i] != AGE_MAX)) begin
                            age_r[i] <= age_r[i] + 1'b1;
                        end
                    end
                    trig_r[sel_idx] <= 1'b1;
                    steal_r         <= sel_steal;
                end else begin
                    gate_r[sel_idx] <= 1'b0;
                end
            end
        end
    end

    // Flatten the per-slot arrays onto the packed output buses.
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
        assign voice_note[7*g +: 7] = note_r[g];
        assign voice_vel[7*g +: 7]  = vel_r[g];
    end

    assign voice_gate = gate_r;
    assign voice_trig = trig_r;
    assign steal      = steal_r;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator
// Directed scenarios followed by random note traffic, checked against a
// slot-level model of the allocation rules kept in the bench.
module tb_midi_voice_allocator;

    localparam int N       = 4;
    localparam int AGE_MAX = 255;

    logic             clk;
    logic             rst_n;
    logic             ev_valid;
    logic             ev_ready;
    logic             ev_on;
    logic [6:0]       ev_note;
    logic [6:0]       ev_vel;
    logic             panic;
    logic [N-1:0]     voice_gate;
    logic [7*N-1:0]   voice_note;
    logic [7*N-1:0]   voice_vel;
    logic [N-1:0]     voice_trig;
    logic             steal;

    int assert_count = 0;
    int fail_count   = 0;

    int m_gate [N];
    int m_note [N];
    int m_vel  [N];
    int m_age  [N];

    midi_voice_allocator #(.NUM_VOICES(N), .AGE_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_on      (ev_on),
        .ev_note    (ev_note),
        .ev_vel     (ev_vel),
        .panic      (panic),
        .voice_gate (voice_gate),
        .voice_note (voice_note),
        .voice_vel  (voice_vel),
        .voice_trig (voice_trig),
        .steal      (steal)
    );

    // 100 MHz bench clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void modelClear(input bit full);
        for (int i = 0; i < N; i++) begin
            m_gate[i] = 0;
            m_age[i]  = 0;
            if (full) begin
                m_note[i] = 0;
                m_vel[i]  = 0;
            end
        end
    endfunction

    // Allocation rules: match, then free, then oldest held slot.
    function automatic void modelEvent(input bit on, input int note, input int vel,
                                       output logic [N-1:0] t, output bit s);
        int chosen;
        int best;
        bit is_on;
        chosen = -1;
        is_on  = on && (vel != 0);
        t      = '0;
        s      = 1'b0;
        for (int i = 0; i < N; i++)
            if (chosen < 0 && m_gate[i] != 0 && m_note[i] == note) chosen = i;
        if (!is_on) begin
            if (chosen >= 0) m_gate[chosen] = 0;
            return;
        end
        for (int i = 0; i < N; i++)
            if (chosen < 0 && m_gate[i] == 0) chosen = i;
        if (chosen < 0) begin
            best = 0;
            for (int i = 1; i < N; i++)
                if (m_age[i] > m_age[best]) best = i;
            chosen = best;
            s = 1'b1;
        end
        for (int i = 0; i < N; i++)
            if (i != chosen && m_gate[i] != 0)
                m_age[i] = (m_age[i] + 1 > AGE_MAX) ? AGE_MAX : m_age[i] + 1;
        m_gate[chosen] = 1;
        m_note[chosen] = note;
        m_vel[chosen]  = vel;
        m_age[chosen]  = 0;
        t[chosen]      = 1'b1;
    endfunction

    task automatic checkModel(input string tag);
        logic [N-1:0]   eg;
        logic [7*N-1:0] en;
        logic [7*N-1:0] ev;
        for (int i = 0; i < N; i++) begin
            eg[i]         = (m_gate[i] != 0);
            en[7*i +: 7]  = 7'(m_note[i]);
            ev[7*i +: 7]  = 7'(m_vel[i]);
        end
        checkOutput({tag, "_gate"}, 32'(voice_gate), 32'(eg));
        checkOutput({tag, "_note"}, 32'(voice_note), 32'(en));
        checkOutput({tag, "_vel"},  32'(voice_vel),  32'(ev));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        modelClear(1'b1);
        @(negedge clk);
    endtask

    // Present one event, follow it through the scan and check the commit.
    task automatic applyStimulus(input bit on, input int note, input int vel);
        logic [N-1:0] exp_trig;
        bit           exp_steal;
        int           low_cnt;
        bit           early;
        @(negedge clk);
        checkOutput("ready_before", 32'(ev_ready), 32'd1);
        ev_valid = 1'b1;
        ev_on    = on;
        ev_note  = 7'(note);
        ev_vel   = 7'(vel);
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        ev_on    = 1'($urandom);
        ev_note  = 7'($urandom);
        ev_vel   = 7'($urandom);
        modelEvent(on, note, vel, exp_trig, exp_steal);
        low_cnt = 0;
        early   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ev_ready) break;
            low_cnt++;
            if (voice_trig != '0 || steal) early = 1'b1;
        end
        checkOutput("ready_low_cycles", 32'(low_cnt), 32'(N + 1));
        checkOutput("early_pulse", 32'(early), 32'd0);
        checkOutput("trig", 32'(voice_trig), 32'(exp_trig));
        checkOutput("steal", 32'(steal), 32'(exp_steal));
        checkModel("commit");
        @(negedge clk);
        checkOutput("trig_one_cycle", 32'(voice_trig), 32'd0);
        checkOutput("steal_one_cycle", 32'(steal), 32'd0);
    endtask

    task automatic doPanicIdle();
        @(negedge clk);
        panic = 1'b1;
        @(posedge clk);
        #1;
        panic = 1'b0;
        modelClear(1'b0);
        @(negedge clk);
        checkModel("panic_idle");
        checkOutput("panic_idle_trig", 32'(voice_trig), 32'd0);
    endtask

    initial begin
        bit          rnd_on;
        int          rnd_note;
        int          rnd_vel;
        bit          any_pulse;
        rst_n    = 1'b0;
        ev_valid = 1'b0;
        ev_on    = 1'b0;
        ev_note  = '0;
        ev_vel   = '0;
        panic    = 1'b0;
        modelClear(1'b1);

        // Reset values.
        @(negedge clk);
        checkOutput("rst_ready", 32'(ev_ready), 32'd1);
        checkOutput("rst_gate", 32'(voice_gate), 32'd0);
        checkOutput("rst_note", 32'(voice_note), 32'd0);
        checkOutput("rst_vel", 32'(voice_vel), 32'd0);
        checkOutput("rst_trig", 32'(voice_trig), 32'd0);
        checkOutput("rst_steal", 32'(steal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First note lands in slot 0.
        $display("[TB] first note-on");
        applyStimulus(1'b1, 60, 100);
        checkOutput("t1_gate", 32'(voice_gate), 32'h1);
        checkOutput("t1_note0", 32'(voice_note[6:0]), 32'd60);
        checkOutput("t1_vel0", 32'(voice_vel[6:0]), 32'd100);

        // Released slot is reused before an untouched higher slot.
        $display("[TB] free slot reuse");
        doReset();
        applyStimulus(1'b1, 60, 90);
        applyStimulus(1'b1, 62, 91);
        applyStimulus(1'b1, 64, 92);
        applyStimulus(1'b0, 62, 0);
        checkOutput("t2_gate_off", 32'(voice_gate), 32'h5);
        checkOutput("t2_note1_held", 32'(voice_note[13:7]), 32'd62);
        applyStimulus(1'b1, 67, 93);
        checkOutput("t2_gate_on", 32'(voice_gate), 32'h7);
        checkOutput("t2_note1_new", 32'(voice_note[13:7]), 32'd67);

        // All slots busy: the oldest slot is stolen.
        $display("[TB] voice steal");
        doReset();
        applyStimulus(1'b1, 60, 10);
        applyStimulus(1'b1, 62, 11);
        applyStimulus(1'b1, 64, 12);
        applyStimulus(1'b1, 65, 13);
        applyStimulus(1'b1, 67, 14);
        checkOutput("t3_notes", 32'(voice_note), {4'h0, 7'd65, 7'd64, 7'd62, 7'd67});
        checkOutput("t3_gate", 32'(voice_gate), 32'hF);

        // Same note retriggers its slot with the new velocity.
        $display("[TB] retrigger");
        doReset();
        applyStimulus(1'b1, 60, 100);
        applyStimulus(1'b1, 60, 50);
        checkOutput("t4_gate", 32'(voice_gate), 32'h1);
        checkOutput("t4_vel0", 32'(voice_vel[6:0]), 32'd50);

        // Zero-velocity note-on releases; unmatched note-off does nothing.
        $display("[TB] velocity zero and unmatched off");
        applyStimulus(1'b1, 60, 0);
        checkOutput("t5_gate", 32'(voice_gate), 32'h0);
        checkOutput("t5_note_held", 32'(voice_note[6:0]), 32'd60);
        applyStimulus(1'b0, 72, 0);

        // Panic during a scan drops the event.
        $display("[TB] panic mid-scan");
        doReset();
        applyStimulus(1'b1, 61, 70);
        @(negedge clk);
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'd63;
        ev_vel   = 7'd80;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        panic = 1'b1;
        @(posedge clk);
        #1;
        panic = 1'b0;
        modelClear(1'b0);
        @(negedge clk);
        checkOutput("panic_gate", 32'(voice_gate), 32'd0);
        checkOutput("panic_ready", 32'(ev_ready), 32'd1);
        checkModel("panic_scan");
        any_pulse = 1'b0;
        repeat (8) begin
            if (voice_trig != '0 || steal) any_pulse = 1'b1;
            @(negedge clk);
        end
        checkOutput("panic_no_trig", 32'(any_pulse), 32'd0);

        // Accept coinciding with panic is discarded.
        $display("[TB] panic with accept");
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'd70;
        ev_vel   = 7'd90;
        panic    = 1'b1;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        panic    = 1'b0;
        @(negedge clk);
        checkOutput("panic_acc_ready", 32'(ev_ready), 32'd1);
        any_pulse = 1'b0;
        repeat (8) begin
            if (voice_trig != '0 || steal || voice_gate != '0) any_pulse = 1'b1;
            @(negedge clk);
        end
        checkOutput("panic_acc_dropped", 32'(any_pulse), 32'd0);
        checkModel("panic_acc");

        // Reset in the middle of a scan.
        $display("[TB] reset mid-scan");
        applyStimulus(1'b1, 66, 40);
        @(negedge clk);
        ev_valid = 1'b1;
        ev_on    = 1'b1;
        ev_note  = 7'd68;
        ev_vel   = 7'd41;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_ready", 32'(ev_ready), 32'd1);
        checkOutput("rst_mid_gate", 32'(voice_gate), 32'd0);
        checkOutput("rst_mid_note", 32'(voice_note), 32'd0);
        checkOutput("rst_mid_vel", 32'(voice_vel), 32'd0);
        modelClear(1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic on a narrow note range to force matches and steals.
        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                doPanicIdle();
            end else begin
                rnd_on   = ($urandom_range(0, 9) < 7);
                rnd_note = 60 + $urandom_range(0, 7);
                rnd_vel  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
                applyStimulus(rnd_on, rnd_note, rnd_vel);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
